// File: rtl/psd_divider_gen_pkg.sv
// rtl/psd_divider_gen_pkg.sv - shared state encoding for the iterative divider
package psd_divider_gen_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

endpackage

// File: rtl/psd_div_step.sv
// rtl/psd_div_step.sv - one restoring division step on unsigned magnitudes
module psd_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  assign w_shifted = {i_rem, i_quo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, i_dvs};
  // a shifted remainder of 2^WIDTH or more always exceeds the divisor,
  // so the trial sign bit is only meaningful when the top bit is clear
  assign w_fits    = w_shifted[WIDTH] | ~w_trial[WIDTH];

  assign o_rem = w_fits ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/psd_divider_gen.sv
// rtl/psd_divider_gen.sv - parametrised signed/unsigned restoring divider with run/busy/done
module psd_divider_gen
  import psd_divider_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] rest,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int               CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_fixed;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_rest;
  logic             r_dz;
  logic             r_ov;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_sgn;
  logic [WIDTH-1:0] r_dvs_mag;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_q_neg;
  logic             r_r_neg;
  logic [CW-1:0]    r_cnt;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_dvd_neg = r_sgn & r_dvd[WIDTH-1];
  assign w_dvs_neg = r_sgn & r_dvs[WIDTH-1];

  psd_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs_mag),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  // busy/done trail the state by one edge; gating run with busy keeps the
  // done cycle as the single idle gap between back-to-back operations
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fixed    <= 1'b0;
      r_quotient <= '0;
      r_rest     <= '0;
      r_dz       <= 1'b0;
      r_ov       <= 1'b0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_sgn      <= 1'b0;
      r_dvs_mag  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_busy  <= (r_state != ST_IDLE);
      r_fixed <= (r_state == ST_FIX);
      r_done  <= r_fixed;
      if (r_fixed) begin
        r_quotient <= r_quo;
        r_rest     <= r_rem;
        r_dz       <= (r_dvs == '0);
        r_ov       <= r_sgn && (r_dvd == MOST_NEG) && (r_dvs == '1);
      end
      case (r_state)
        ST_IDLE: begin
          if (run && !r_busy) begin
            r_dvd   <= dividend;
            r_dvs   <= divisor;
            r_sgn   <= signed_mode;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_quo     <= w_dvd_neg ? -r_dvd : r_dvd;
          r_dvs_mag <= w_dvs_neg ? -r_dvs : r_dvs;
          r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
          r_r_neg   <= w_dvd_neg;
          r_rem     <= '0;
          r_cnt     <= CNT_LAST;
          r_state   <= ST_ITER;
        end
        ST_ITER: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) r_state <= ST_FIX;
        end
        ST_FIX: begin
          r_quo   <= r_q_neg ? -r_quo : r_quo;
          r_rem   <= r_r_neg ? -r_rem : r_rem;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign rest        = r_rest;
  assign div_by_zero = r_dz;
  assign overflow    = r_ov;

endmodule
